uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//   Parametrised UART transmitter: serialises one word per frame onto TX, LSB first.
//   Frame format is set at elaboration: data width, parity mode and stop-bit count.
//   Words enter through a valid/ready handshake. The block runs on the single system clock CLK;
//   bit timing comes from an internal baud-tick enable, not a divided clock.
//   Sits between a host-side producer (FIFO or register bank) and the board UART pin.
// PARAMETERS
//   CLK_HZ     12_000_000  system clock frequency in Hz
//   BAUD       9600        line rate in bit/s; DIV = round(CLK_HZ/BAUD) = 1250 at defaults
//   DATA_BITS  8           payload bits per frame, legal range 5..9
//   PARITY     0           0 = none, 1 = odd, 2 = even
//   STOP_BITS  1           1 or 2
// PORTS
//   CLK       in   1          system clock, rising edge
//   RST       in   1          asynchronous reset, active-high
//   TX_DATA   in   DATA_BITS  word to send; sampled only on the accept cycle
//   TX_VALID  in   1          producer has a word
//   TX_READY  out  1          block can accept; accept = TX_VALID & TX_READY at a CLK edge
//   TX        out  1          serial line, idle high, registered
//   BUSY      out  1          high from the accept edge until the last stop bit ends
// BEHAVIOUR
//   - Reset (asynchronous, active-high):
//     - TX=1, TX_READY=1, BUSY=0, state IDLE, baud counter=0, shift register cleared.
//     - Reset mid-frame aborts the frame. TX goes to 1 immediately; the frame is never resumed.
//   - States IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     - IDLE: TX=1, TX_READY=1. On accept: latch TX_DATA into the shift register,
//       clear the baud counter, go to START.
//     - START: TX=0 for DIV cycles.
//     - DATA: DATA_BITS slots of DIV cycles each, LSB first. Shift right at each slot end.
//     - PARITY (only if PARITY!=0): one slot. The bit makes the total count of ones in
//       data+parity odd (PARITY=1) or even (PARITY=2).
//     - STOP: TX=1 for STOP_BITS*DIV cycles, then go to IDLE.
//   - Latency: TX falls on the first CLK edge after the accept edge, and every bit lasts
//     exactly DIV cycles.
//   - Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles, counted from
//     the TX fall to IDLE re-entry.
//   - TX_READY=0 in every state except IDLE. TX_VALID while not ready is ignored, and the
//     producer holds the word.
//   - Back-to-back: with TX_VALID held high, the next frame is accepted in the single IDLE
//     cycle. Minimum inter-frame gap is 1 CLK beyond the stop bits.
//   - TX_DATA changes after the accept edge have no effect on the frame in flight.
//   - Parity is computed from the latched word, not from the live input.
//   - Baud counter runs 0..DIV-1. A tick is asserted when the count is DIV-1; the counter then
//     wraps to 0. The counter is held at 0 in IDLE.
//   - Bit counter width is clog2(DATA_BITS+1). It wraps only through the state change,
//     never by overflow.
//   - Elaboration errors: DIV<2, DATA_BITS outside 5..9, PARITY>2, STOP_BITS not in {1,2}.
// STRUCTURE
//   - Package uart_pkg:
//     - PARITY_NONE/ODD/EVEN constants
//     - tx state encoding (localparams, one-hot or binary)
//     - function calc_div(CLK_HZ, BAUD), rounding to nearest
//   - Sub-module uart_baud_tick (params DIV):
//     - ports CLK, RST, CLR, TICK
//     - counter with synchronous clear, one-cycle TICK pulse
//   - The top level holds the FSM, shift register, bit counter, parity accumulator and TX register.
// TESTING  (override CLK_HZ=16, BAUD=1 so DIV=16 unless stated)
//   1. Assert RST for 3 cycles, release -> TX=1, TX_READY=1, BUSY=0. Assert RST mid-frame
//      (during DATA bit 3) -> TX=1 in the same cycle, TX_READY=1 after release, no further
//      edges on TX.
//   2. 8N1, send 0xA5 -> TX holds 0,1,0,1,0,0,1,0,1,1, each for 16 cycles.
//      TX_READY low for 160 cycles; TX falls 1 cycle after accept.
//   3. DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x41 -> 0,1,0,0,0,0,0,1, parity 0, stop 1,1
//      (11 slots = 176 cycles). With PARITY=1 the parity bit is 1.
//   4. TX_VALID held high with words 0x00 then 0xFF -> two frames with exactly one CLK of
//      TX=1 gap beyond stop. Second frame data slots are all 1.
//   5. Change TX_DATA every cycle during a frame, and pulse TX_VALID while BUSY ->
//      transmitted word equals the value at the accept edge; no extra frame is accepted.
//   6. Defaults (12 MHz, 9600) -> start bit width measured as 1250 cycles;
//      scoreboard decodes 256 random 8N1 words with zero mismatches.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, tx state encoding and baud divider helper
// for the parametrised UART transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word handshake between a host producer
// and the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] TX_DATA;
  logic                 TX_VALID;
  logic                 TX_READY;

  modport master (
    output TX_DATA,
    output TX_VALID,
    input  TX_READY
  );

  modport slave (
    input  TX_DATA,
    input  TX_VALID,
    output TX_READY
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..DIV-1 counter with synchronous clear;
// TICK pulses for one cycle on the last count of each bit slot.
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign TICK = (cnt == CW'(DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR || TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, one word per frame,
// LSB first, bit timing from an internal baud-tick enable.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_param_if.slave host,
  output logic           TX,
  output logic           BUSY
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam bit HAS_PAR = (PARITY != PARITY_NONE);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
    $error("uart_tx_param: illegal frame configuration");
  end

  tx_state_t            st_q;
  tx_state_t            st_d;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 par_acc;
  logic                 tick;
  logic                 clr;
  logic                 ready;
  logic                 busy;
  logic                 tx_d;
  logic                 accept;
  logic                 last_bit;
  logic                 last_stop;

  assign accept        = host.TX_VALID & ready;
  assign host.TX_READY = ready;
  assign BUSY          = busy;
  assign clr           = (st_q == S_IDLE);
  assign last_bit      = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop     = (bit_cnt == BW'(STOP_BITS - 1));

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (clr),
    .TICK (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:   if (accept) st_d = S_START;
      S_START:  if (tick) st_d = S_DATA;
      S_DATA:   if (tick && last_bit)
                  st_d = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (tick) st_d = S_STOP;
      S_STOP:   if (tick && last_stop) st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b1;
    tx_d  = 1'b1;
    unique case (st_q)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg[0];
      S_PARITY: tx_d = par_acc;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Bit counter is shared by data slots and stop slots; it restarts on
  // every state change so it never has to wrap on its own.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_acc <= 1'b0;
    end else if (accept) begin
      shreg   <= host.TX_DATA;
      bit_cnt <= '0;
      par_acc <= (PARITY == PARITY_ODD);
    end else if (tick) begin
      if (st_q == S_DATA) begin
        shreg   <= shreg >> 1;
        par_acc <= par_acc ^ shreg[0];
      end
      if (st_d != st_q) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX <= 1'b1;
    end else begin
      TX <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed checks of the UART transmitter in four
// frame configurations, plus a random 8N1 scoreboard.
module tb_uart_tx_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       va = 1'b0;
  logic       vb = 1'b0;
  logic       vd = 1'b0;
  logic [7:0] da = '0;
  logic [6:0] db = '0;
  logic [7:0] dd = '0;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  int         errs = 0;
  int         n_chk = 0;

  logic [15:0] cb [4];
  int          cn [4];
  int          crl [4];
  logic        ct0 [4];
  logic        cbz0 [4];

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(7)) if_b ();
  uart_tx_param_if #(.DATA_BITS(7)) if_c ();
  uart_tx_param_if #(.DATA_BITS(8)) if_d ();

  assign if_a.TX_VALID = va;
  assign if_a.TX_DATA  = da;
  assign if_b.TX_VALID = vb;
  assign if_b.TX_DATA  = db;
  assign if_c.TX_VALID = vb;
  assign if_c.TX_DATA  = db;
  assign if_d.TX_VALID = vd;
  assign if_d.TX_DATA  = dd;

  uart_tx_param #(
    .CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .CLK(clk), .RST(rst), .host(if_a.slave), .TX(tx_a), .BUSY(busy_a)
  );

  uart_tx_param #(
    .CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .CLK(clk), .RST(rst), .host(if_b.slave), .TX(tx_b), .BUSY(busy_b)
  );

  uart_tx_param #(
    .CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) u_c (
    .CLK(clk), .RST(rst), .host(if_c.slave), .TX(tx_c), .BUSY(busy_c)
  );

  uart_tx_param u_d (
    .CLK(clk), .RST(rst), .host(if_d.slave), .TX(tx_d), .BUSY(busy_d)
  );

  wire [3:0] txv   = {tx_d, tx_c, tx_b, tx_a};
  wire [3:0] busyv = {busy_d, busy_c, busy_b, busy_a};
  wire [3:0] rdyv  = {if_d.TX_READY, if_c.TX_READY,
                      if_b.TX_READY, if_a.TX_READY};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic [7:0] w);
    case (s)
      0: begin va = v; da = w; end
      1: begin vb = v; db = w[6:0]; end
      default: begin vd = v; dd = w; end
    endcase
  endtask

  // Raise valid, wait (bounded) for ready, return #1 after accept edge.
  task automatic accept(input int s, input logic [7:0] w, input logic keep);
    int n;
    n = 0;
    drive(s, 1'b1, w);
    while (!rdyv[s] && n < 400) begin
      step();
      n++;
    end
    chk("accept_ready", rdyv[s], 1'b1);
    step();
    if (!keep) drive(s, 1'b0, w);
  endtask

  // Called #1 after an accept edge; records each slot's value at its
  // first cycle and counts any later change inside the slot.
  task automatic capture(input int div, input int ns);
    logic [3:0] t;
    logic [3:0] r;
    int s;
    t = txv;
    r = busyv;
    for (int i = 0; i < 4; i++) begin
      cb[i] = '0; cn[i] = 0; crl[i] = 0;
      ct0[i] = t[i]; cbz0[i] = r[i];
    end
    for (int k = 0; k <= div * ns; k++) begin
      t = txv;
      r = rdyv;
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) crl[i]++;
        if (k > 0) begin
          s = (k - 1) / div;
          if ((k - 1) % div == 0) cb[i][s] = t[i];
          else if (t[i] !== cb[i][s]) cn[i]++;
        end
      end
      if (k < div * ns) step();
    end
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] w;
    logic [7:0] exp_w;
    logic prev;
    int edges;
    int cnt;
    int mism;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_ready", if_a.TX_READY, 1'b1);
    chk("rst_busy", busy_a, 1'b0);

    // 8N1 0xA5
    accept(0, 8'hA5, 1'b0);
    da = 8'h00;
    capture(16, 10);
    chk("a5_lat_tx", ct0[0], 1'b1);
    chk("a5_busy", cbz0[0], 1'b1);
    chk("a5_bits", cb[0][9:0], 10'h34A);
    chk("a5_width", cn[0], 0);
    chk("a5_ready_low", crl[0], 160);

    // 7E2 and 7O2 with 0x41
    accept(1, 8'h41, 1'b0);
    capture(16, 11);
    chk("even_bits", cb[1][10:0], 11'h682);
    chk("even_width", cn[1], 0);
    chk("even_ready_low", crl[1], 176);
    chk("odd_bits", cb[2][10:0], 11'h782);
    chk("odd_width", cn[2], 0);

    // back-to-back with valid held high
    accept(0, 8'h00, 1'b1);
    da = 8'hFF;
    capture(16, 10);
    chk("b2b_f1", cb[0][9:0], 10'h200);
    step();
    drive(0, 1'b0, 8'h00);
    capture(16, 10);
    chk("b2b_gap_tx", ct0[0], 1'b1);
    chk("b2b_accepted", cbz0[0], 1'b1);
    chk("b2b_f2", cb[0][9:0], 10'h3FE);
    chk("b2b_width", cn[0], 0);

    // data churn and valid pulses while busy
    accept(0, 8'h3C, 1'b0);
    fork
      capture(16, 10);
      begin
        repeat (150) begin
          @(posedge clk);
          #2;
          da = 8'($urandom);
          va = ~va;
        end
        va = 1'b0;
      end
    join
    chk("churn_bits", cb[0][9:0], 10'h278);
    cnt = 0;
    repeat (40) begin
      step();
      if (busy_a) cnt++;
    end
    chk("churn_no_extra", cnt, 0);

    // reset during data bit 3
    accept(0, 8'h00, 1'b0);
    repeat (70) step();
    chk("mid_pre_tx", tx_a, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx_a, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_ready", if_a.TX_READY, 1'b1);
    edges = 0;
    prev = tx_a;
    repeat (200) begin
      step();
      if (tx_a !== prev) edges++;
      prev = tx_a;
    end
    chk("mid_no_edges", edges, 0);

    // random 8N1 scoreboard
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      q.push_back(w);
      accept(0, w, 1'b0);
      capture(16, 10);
      exp_w = q.pop_front();
      if (cb[0][0] !== 1'b0 || cb[0][9] !== 1'b1 ||
          cb[0][8:1] !== exp_w || cn[0] != 0)
        mism++;
    end
    chk("sb_mismatch", mism, 0);

    // defaults: 12 MHz / 9600 start bit
    accept(3, 8'h55, 1'b0);
    cnt = 0;
    while (tx_d && cnt < 10) begin
      step();
      cnt++;
    end
    chk("def_latency", cnt, 1);
    cnt = 0;
    while (!tx_d && cnt < 3000) begin
      step();
      cnt++;
    end
    chk("def_start_width", cnt, 1250);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
endmodule
